tap_controller: RTL and testbench
=================================

TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h10A0_D0C1, 32-bit device identification; bit 0 SHALL be 1.
REQ-002 TCK  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 TMS  input  1  test mode select, sampled on TCK rising edge.
REQ-005 TDI  input  1  serial test data in; also drives the boundary chain TDI directly.
REQ-006 chain_tdo  input  1  serial output of the boundary scan chain.
REQ-007 ShiftDR  output  1  boundary chain shift select (1 = shift, 0 = capture).
REQ-008 ClockDR  output  1  boundary chain capture/shift strobe.
REQ-009 UpdateDR  output  1  boundary chain update strobe.
REQ-010 Mode  output  1  boundary cell output select (1 = drive scanned values to pins).
REQ-011 TDO  output  1  serial test data out.
REQ-012 TDO_en  output  1  high while TDO carries valid shift data.
REQ-013 state  output  4  current TAP state encoding, for debug.
REQ-014 ir  output  4  current (updated) instruction.

Function
REQ-015 The FSM SHALL implement the 16 IEEE 1149.1 states with encodings TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-016 Transitions (TMS=1 : TMS=0): TLR->TLR:RTI; RTI->SelDR:RTI; SelDR->SelIR:CapDR; Cap/Sh->Ex1:Sh; Ex1->Upd:Pau; Pau->Ex2:Pau; Ex2->Upd:Sh; Upd->SelDR:RTI; SelIR->TLR:CapIR; IR branch mirrors DR branch.
REQ-017 Five consecutive TMS=1 cycles SHALL reach TLR from any state.
REQ-018 Instructions: EXTEST=0000, SAMPLE=0001, IDCODE=0010, BYPASS=1111; any other code SHALL decode as BYPASS.
REQ-019 IR shift register: CapIR loads 4'b0101; ShIR shifts right with TDI into MSB; UpdIR copies shift register to ir.
REQ-020 Entering TLR SHALL set ir to IDCODE.
REQ-021 Boundary selected = ir is EXTEST or SAMPLE; all chain strobes SHALL be 0 when not selected.
REQ-022 ClockDR = 1 in CapDR and ShDR when boundary selected; ShiftDR = 1 only in ShDR when selected; UpdateDR = 1 only in UpdDR when selected; all decoded combinationally from state.
REQ-023 Mode = 1 iff ir == EXTEST.
REQ-024 Bypass register (1 bit): CapDR loads 0; ShDR loads TDI.
REQ-025 IDCODE register (32 bits): CapDR loads IDCODE_VALUE; ShDR shifts right with TDI into bit 31.
REQ-026 TDO mux, combinational: ShIR -> IR shift bit 0; ShDR -> IDCODE bit 0, bypass bit, or chain_tdo per ir; all other states -> 0.
REQ-027 TDO_en = 1 exactly in ShDR and ShIR.
REQ-028 Pause/Exit states SHALL hold all shift registers unchanged.
REQ-029 A new ir takes effect on the cycle after UpdIR; a DR scan in progress SHALL never see a changed ir.

Reset
REQ-030 Reset=1 at a rising edge SHALL force state=TLR and ir=IDCODE, and clear the IR shift, bypass and IDCODE shift registers; it overrides TMS.
REQ-031 During and after reset: ShiftDR=ClockDR=UpdateDR=Mode=TDO=TDO_en=0.
REQ-032 Reset asserted mid-shift SHALL abandon the scan with no update strobe.

Structure
REQ-033 A shared package SHALL hold the 16 state encodings, the instruction codes, IR width (4) and the IR capture value.
REQ-034 The FSM SHALL be a sub-module, tap_fsm (TCK, Reset, TMS -> state); instruction decode, data registers and TDO mux stay in tap_controller.

Verification
REQ-035 Reset, then TMS=0,1,1,1,1,1 -> state goes C, then F after the fifth 1; ir=0010.
REQ-036 From TLR, TMS 0,1,0,0 then 32 ShDR cycles -> TDO carries 0x10A0D0C1 LSB first; TDO_en=1 throughout.
REQ-037 Shift IR=1111 with TMS=1 on the last bit, then UpdIR -> first 4 TDO bits = 1,0,1,0; ir=1111; a DR shift of TDI 1,0,1,1 yields TDO 0,1,0,1.
REQ-038 Load EXTEST -> Mode=1 from the cycle after UpdIR; CapDR: ClockDR=1, ShiftDR=0; ShDR: both 1, TDO=chain_tdo; UpdDR: UpdateDR=1 for exactly one cycle.
REQ-039 SAMPLE loaded -> strobes behave as in EXTEST but Mode=0; code 0110 -> behaves as BYPASS.
REQ-040 Reset pulsed in ShDR under EXTEST -> next cycle state=F, ir=0010, Mode=0, no UpdateDR pulse.

Source files
------------

// File: rtl/tap_controller_pkg.sv
// ---------------------------------------------------------------------------
// tap_controller_pkg
// Shared definitions for the JTAG TAP controller:
//   - tap_state_e : the 16 TAP states with their fixed 4-bit encodings
//   - instruction codes, IR width and IR capture pattern
//   - instr_e / decode_instr : maps a raw IR value onto the operation it selects
// ---------------------------------------------------------------------------
package tap_controller_pkg;

    localparam int IR_WIDTH = 4;

    typedef enum logic [3:0] {
        TLR     = 4'hF,
        RTI     = 4'hC,
        SEL_DR  = 4'h7,
        CAP_DR  = 4'h6,
        SH_DR   = 4'h2,
        EX1_DR  = 4'h1,
        PAU_DR  = 4'h3,
        EX2_DR  = 4'h0,
        UPD_DR  = 4'h5,
        SEL_IR  = 4'h4,
        CAP_IR  = 4'hE,
        SH_IR   = 4'hA,
        EX1_IR  = 4'h9,
        PAU_IR  = 4'hB,
        EX2_IR  = 4'h8,
        UPD_IR  = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = 4'b0000;
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = 4'b0001;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 4'b0010;
    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = 4'b1111;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

    typedef enum logic [1:0] {
        INSTR_EXTEST,
        INSTR_SAMPLE,
        INSTR_IDCODE,
        INSTR_BYPASS
    } instr_e;

    // Unknown opcodes fall back to BYPASS so a stray code never touches pins.
    function automatic instr_e decode_instr(input logic [IR_WIDTH-1:0] code);
        instr_e res;
        case (code)
            IR_EXTEST: res = INSTR_EXTEST;
            IR_SAMPLE: res = INSTR_SAMPLE;
            IR_IDCODE: res = INSTR_IDCODE;
            default:   res = INSTR_BYPASS;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tap_controller_fsm.sv
// ---------------------------------------------------------------------------
// tap_fsm
// IEEE 1149.1 TAP state machine.
// Ports:
//   TCK   in  : test clock, all transitions on rising edge
//   Reset in  : synchronous active-high reset, forces Test-Logic-Reset
//   TMS   in  : test mode select
//   state out : current state encoding (tap_state_e values)
// ---------------------------------------------------------------------------
module tap_fsm
    import tap_controller_pkg::*;
(
    input  logic       TCK,
    input  logic       Reset,
    input  logic       TMS,
    output logic [3:0] state
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge TCK) begin
        if (Reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/tap_controller.sv
// ---------------------------------------------------------------------------
// tap_controller
// JTAG TAP with IR, BYPASS, IDCODE and control of an external boundary chain.
// Parameter:
//   IDCODE_VALUE : 32-bit device ID, bit 0 must be 1
// Ports:
//   TCK, Reset          : clock and synchronous active-high reset
//   TMS, TDI            : JTAG control / serial data in
//   chain_tdo           : serial output of the boundary chain
//   ShiftDR, ClockDR,
//   UpdateDR, Mode      : boundary chain controls
//   TDO, TDO_en         : serial data out and its valid flag
//   state, ir           : current TAP state and active instruction (debug)
// ---------------------------------------------------------------------------
module tap_controller
    import tap_controller_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h10A0_D0C1
) (
    input  logic                TCK,
    input  logic                Reset,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                chain_tdo,
    output logic                ShiftDR,
    output logic                ClockDR,
    output logic                UpdateDR,
    output logic                Mode,
    output logic                TDO,
    output logic                TDO_en,
    output logic [3:0]          state,
    output logic [IR_WIDTH-1:0] ir
);

    tap_state_e cur_state;

    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_sr_q, idcode_sr_d;

    instr_e instr;
    logic   boundary_sel;
    logic   entering_tlr;

    tap_fsm u_fsm (
        .TCK   (TCK),
        .Reset (Reset),
        .TMS   (TMS),
        .state (state)
    );

    assign cur_state    = tap_state_e'(state);
    assign instr        = decode_instr(ir_q);
    assign boundary_sel = (instr == INSTR_EXTEST) || (instr == INSTR_SAMPLE);

    // TLR is only reachable from SelIR or by staying in TLR, both with TMS=1.
    // Loading IDCODE on that edge makes ir valid on the first cycle in TLR.
    assign entering_tlr = TMS && ((cur_state == TLR) || (cur_state == SEL_IR));

    always_ff @(posedge TCK) begin
        if (Reset) begin
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            bypass_q    <= 1'b0;
            idcode_sr_q <= '0;
        end else begin
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            bypass_q    <= bypass_d;
            idcode_sr_q <= idcode_sr_d;
        end
    end

    // ir only changes leaving UpdIR, so no DR scan ever straddles an update.
    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        bypass_d    = bypass_q;
        idcode_sr_d = idcode_sr_q;
        case (cur_state)
            CAP_IR: ir_sr_d = IR_CAPTURE;
            SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            UPD_IR: ir_d    = ir_sr_q;
            CAP_DR: begin
                bypass_d    = 1'b0;
                idcode_sr_d = IDCODE_VALUE;
            end
            SH_DR: begin
                bypass_d    = TDI;
                idcode_sr_d = {TDI, idcode_sr_q[31:1]};
            end
            default: ;
        endcase
        if (entering_tlr) begin
            ir_d = IR_IDCODE;
        end
    end

    // Chain strobes and TDO are gated by Reset so they drop the moment reset
    // is raised, not only after the next edge; this also kills any UpdateDR.
    always_comb begin
        ClockDR  = 1'b0;
        ShiftDR  = 1'b0;
        UpdateDR = 1'b0;
        Mode     = 1'b0;
        TDO      = 1'b0;
        TDO_en   = 1'b0;
        if (!Reset) begin
            Mode = (instr == INSTR_EXTEST);
            if (boundary_sel) begin
                ClockDR  = (cur_state == CAP_DR) || (cur_state == SH_DR);
                ShiftDR  = (cur_state == SH_DR);
                UpdateDR = (cur_state == UPD_DR);
            end
            if (cur_state == SH_IR) begin
                TDO    = ir_sr_q[0];
                TDO_en = 1'b1;
            end else if (cur_state == SH_DR) begin
                TDO_en = 1'b1;
                case (instr)
                    INSTR_IDCODE: TDO = idcode_sr_q[0];
                    INSTR_EXTEST,
                    INSTR_SAMPLE: TDO = chain_tdo;
                    default:      TDO = bypass_q;
                endcase
            end
        end
    end

    assign ir = ir_q;

endmodule

// File: tb/tb_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_tap_controller
// Directed JTAG scenarios followed by randomized TMS/TDI/chain/reset traffic.
// Every cycle the DUT outputs are compared with a reference model built from
// the state transition table and the register rules of the TAP.
// ---------------------------------------------------------------------------
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       Reset = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       chain_tdo = 1'b0;
    logic       ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_en;
    logic [3:0] state;
    logic [3:0] ir;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IDCODE = 32'h10A0_D0C1;

    tap_controller #(.IDCODE_VALUE(IDCODE)) dut (
        .TCK       (TCK),
        .Reset     (Reset),
        .TMS       (TMS),
        .TDI       (TDI),
        .chain_tdo (chain_tdo),
        .ShiftDR   (ShiftDR),
        .ClockDR   (ClockDR),
        .UpdateDR  (UpdateDR),
        .Mode      (Mode),
        .TDO       (TDO),
        .TDO_en    (TDO_en),
        .state     (state),
        .ir        (ir)
    );

    always #5 TCK = ~TCK;

    // Reference model: next-state table indexed by state encoding.
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int        m_state;
    bit [3:0]  m_ir;
    bit [3:0]  m_irsr;
    bit [31:0] m_id;
    bit        m_byp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] model_outs(input bit rst, input bit chn);
        bit sel, e_sh, e_ck, e_up, e_md, e_tdo, e_en;
        sel   = (m_ir == 4'd0) || (m_ir == 4'd1);
        e_sh  = !rst && sel && (m_state == 2);
        e_ck  = !rst && sel && (m_state == 2 || m_state == 6);
        e_up  = !rst && sel && (m_state == 5);
        e_md  = !rst && (m_ir == 4'd0);
        e_en  = !rst && (m_state == 2 || m_state == 10);
        e_tdo = 1'b0;
        if (!rst && m_state == 10) e_tdo = m_irsr[0];
        if (!rst && m_state == 2)
            e_tdo = (m_ir == 4'd2) ? m_id[0] : (sel ? chn : m_byp);
        return {4'(m_state), m_ir, e_sh, e_ck, e_up, e_md, e_tdo, e_en};
    endfunction

    task automatic model_step(input bit rst, input bit tms, input bit tdi);
        int ns;
        if (rst) begin
            m_state = 15; m_ir = 4'd2; m_irsr = 0; m_id = 0; m_byp = 0;
            return;
        end
        ns = tms ? nxt1[m_state] : nxt0[m_state];
        case (m_state)
            14: m_irsr = 4'b0101;
            10: m_irsr = (m_irsr >> 1) | (4'(tdi) << 3);
            13: m_ir   = m_irsr;
            6:  begin m_id = IDCODE; m_byp = 0; end
            2:  begin m_id = (m_id >> 1) | (32'(tdi) << 31); m_byp = tdi; end
            default: ;
        endcase
        if (ns == 15) m_ir = 4'd2;
        m_state = ns;
    endtask

    // One TCK cycle: apply inputs, compare against model, clock, advance model.
    task automatic drive(input bit rst, input bit tms, input bit tdi, input bit chn);
        Reset = rst; TMS = tms; TDI = tdi; chain_tdo = chn;
        #1;
        check_val("outs", {18'd0, state, ir, ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_en},
                  {18'd0, model_outs(rst, chn)});
        @(posedge TCK);
        model_step(rst, tms, tdi);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] code);
        drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, i == 3, code[i], 0);
        drive(0, 1, 0, 0);
        check_val("ir_held_in_updir", {28'd0, ir}, {28'd0, m_ir});
        drive(0, 0, 0, 0);
        check_val("ir_loaded", {28'd0, ir}, {28'd0, code});
        $display("load_ir code=%b ir=%b mode=%0b", code, ir, Mode);
    endtask

    task automatic boundary_scan(input bit exp_mode);
        check_val("bs_mode", {31'd0, Mode}, {31'd0, exp_mode});
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check_val("capdr_strobes", {30'd0, ClockDR, ShiftDR}, 32'b10);
        drive(0, 0, 0, 1);
        check_val("shdr_strobes", {30'd0, ClockDR, ShiftDR}, 32'b11);
        check_val("shdr_tdo_chain1", {31'd0, TDO}, 32'd1);
        chain_tdo = 1'b0; #1;
        check_val("shdr_tdo_chain0", {31'd0, TDO}, 32'd0);
        drive(0, 1, 1, 0);
        check_val("ex1_no_update", {31'd0, UpdateDR}, 32'd0);
        drive(0, 1, 0, 0);
        check_val("upddr_pulse", {31'd0, UpdateDR}, 32'd1);
        drive(0, 0, 0, 0);
        check_val("upddr_pulse_end", {31'd0, UpdateDR}, 32'd0);
        $display("boundary_scan mode=%0b done", exp_mode);
    endtask

    logic [31:0] cap;

    initial begin
        // Initial reset without comparison: DUT state is unknown before it.
        Reset = 1; TMS = 1;
        @(posedge TCK); #1;
        model_step(1, 1, 0);

        // Reset behaviour and TLR return with five TMS=1.
        drive(1, 0, 0, 0);
        check_val("reset_state", {28'd0, state}, 32'hF);
        check_val("reset_ir", {28'd0, ir}, 32'h2);
        check_val("reset_outs", {26'd0, ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDO_en}, 32'd0);
        drive(0, 0, 0, 0);
        check_val("rti_state", {28'd0, state}, 32'hC);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0);
        check_val("tlr_after_5", {28'd0, state}, 32'hF);
        check_val("tlr_ir", {28'd0, ir}, 32'h2);
        $display("reset/tlr state=%h ir=%b", state, ir);

        // IDCODE readout.
        drive(0, 0, 0, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        cap = 0;
        for (int i = 0; i < 32; i++) begin
            cap[i] = TDO;
            check_val("idcode_en", {31'd0, TDO_en}, 32'd1);
            drive(0, i == 31, 0, 0);
        end
        check_val("idcode_value", cap, IDCODE);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        $display("idcode read %h", cap);

        // IR capture pattern, BYPASS load and bypass shift.
        drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        cap = 0;
        for (int i = 0; i < 4; i++) begin
            cap[i] = TDO;
            drive(0, i == 3, 1, 0);
        end
        check_val("ir_capture_bits", cap, 32'b0101);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        check_val("ir_bypass", {28'd0, ir}, 32'hF);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        cap = 0;
        for (int i = 0; i < 4; i++) begin
            cap[i] = TDO;
            drive(0, i == 3, (i != 1), 0);
        end
        check_val("bypass_bits", cap, 32'b1010);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        $display("bypass scan tdo=%b", cap[3:0]);

        // EXTEST, SAMPLE, undefined code.
        load_ir(4'b0000);
        boundary_scan(1'b1);
        load_ir(4'b0001);
        boundary_scan(1'b0);
        load_ir(4'b0110);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        check_val("op6_no_clockdr", {31'd0, ClockDR}, 32'd0);
        drive(0, 0, 1, 1);
        check_val("op6_bypass_first", {31'd0, TDO}, 32'd0);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 0);
        check_val("op6_no_update", {31'd0, UpdateDR}, 32'd0);
        drive(0, 0, 0, 0);

        // Reset in the middle of an EXTEST shift.
        load_ir(4'b0000);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 1, 0);
        check_val("pre_reset_shift", {31'd0, ShiftDR}, 32'd1);
        drive(1, 1, 0, 0);
        check_val("midreset_state", {28'd0, state}, 32'hF);
        check_val("midreset_ir", {28'd0, ir}, 32'h2);
        check_val("midreset_mode_upd", {30'd0, Mode, UpdateDR}, 32'd0);
        $display("mid-shift reset state=%h ir=%b", state, ir);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        $display("random traffic 4000 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
